// File: rtl/decode_issue_ctrl_if.sv
// Fetch/decode handshake, immediate-generator link and stall counter of the decode issue controller.
// master = environment side (fetch, generator, downstream); slave = the controller.
interface decode_issue_ctrl_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
);
    logic              f_valid_i;
    logic              f_ready_o;
    logic [AWIDTH-1:0] f_pc_i;
    logic [DWIDTH-1:0] f_insn_i;
    logic              flush_i;
    logic [6:0]        igen_opcode_o;
    logic [DWIDTH-1:0] igen_insn_o;
    logic [31:0]       igen_imm_i;
    logic              d_valid_o;
    logic              d_ready_i;
    logic [AWIDTH-1:0] d_pc_o;
    logic [DWIDTH-1:0] d_insn_o;
    logic [31:0]       d_imm_o;
    logic [CWIDTH-1:0] stall_cnt_o;

    modport master (
        output f_valid_i, f_pc_i, f_insn_i, flush_i, igen_imm_i, d_ready_i,
        input  f_ready_o, igen_opcode_o, igen_insn_o, d_valid_o, d_pc_o,
               d_insn_o, d_imm_o, stall_cnt_o
    );

    modport slave (
        input  f_valid_i, f_pc_i, f_insn_i, flush_i, igen_imm_i, d_ready_i,
        output f_ready_o, igen_opcode_o, igen_insn_o, d_valid_o, d_pc_o,
               d_insn_o, d_imm_o, stall_cnt_o
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode issue controller: decode register plus one-entry skid register,
// immediate taken from an external combinational generator, saturating stall counter.
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | decode register empty, skid empty
// BUSY  | decode register holds an instruction, skid empty
// FULL  | decode register and skid both hold instructions
module decode_issue_ctrl #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    decode_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] s_pc;
    logic [DWIDTH-1:0] s_insn;
    logic [AWIDTH-1:0] d_pc;
    logic [DWIDTH-1:0] d_insn;
    logic [31:0]       d_imm;
    logic [CWIDTH-1:0] stall_cnt;

    logic              s_valid;
    logic              d_valid;
    logic              accept;
    logic              d_load;
    logic              s_load;
    logic [AWIDTH-1:0] src_pc;
    logic [DWIDTH-1:0] src_insn;

    assign d_valid  = (state != EMPTY);
    assign s_valid  = (state == FULL);
    assign accept   = bus.f_valid_i && !s_valid;
    assign src_pc   = s_valid ? s_pc : bus.f_pc_i;
    assign src_insn = s_valid ? s_insn : bus.f_insn_i;

    assign bus.f_ready_o     = !s_valid;
    assign bus.igen_insn_o   = src_insn;
    assign bus.igen_opcode_o = src_insn[6:0];
    assign bus.d_valid_o     = d_valid;
    assign bus.d_pc_o        = d_pc;
    assign bus.d_insn_o      = d_insn;
    assign bus.d_imm_o       = d_imm;
    assign bus.stall_cnt_o   = stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        d_load    = 1'b0;
        s_load    = 1'b0;
        if (bus.flush_i) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        d_load    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.d_ready_i) begin
                        d_load    = accept;
                        state_nxt = accept ? BUSY : EMPTY;
                    end else if (accept) begin
                        s_load    = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    // generator source is the skid here, so D picks up S with its immediate
                    if (bus.d_ready_i) begin
                        d_load    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_pc   <= '0;
            d_insn <= NOP_INSN;
            d_imm  <= '0;
        end else if (d_load) begin
            d_pc   <= src_pc;
            d_insn <= src_insn;
            d_imm  <= bus.igen_imm_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_pc   <= '0;
            s_insn <= NOP_INSN;
        end else if (s_load) begin
            s_pc   <= bus.f_pc_i;
            s_insn <= bus.f_insn_i;
        end
    end

    // counts backpressured cycles regardless of flush; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (d_valid && !bus.d_ready_i && (stall_cnt != {CWIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CWIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus random traffic checked each cycle
// against an in-order queue model of the held instructions.
module tb_decode_issue_ctrl;
    localparam int CW      = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
    } ent_t;

    logic clk;
    logic reset;
    decode_issue_ctrl_if #(.AWIDTH(32), .DWIDTH(32), .CWIDTH(CW)) bus ();

    decode_issue_ctrl #(.AWIDTH(32), .DWIDTH(32), .CWIDTH(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ent_t held[$];
    int   stall_m;
    int   n_chk;
    int   n_pass;

    // RISC-V immediate generator standing in for the real one
    function automatic logic [31:0] imm_of(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: imm_of = {{20{i[31]}}, i[31:20]};
            7'h23:               imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:               imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17:        imm_of = {i[31:12], 12'h000};
            7'h6F:               imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:             imm_of = 32'h0;
        endcase
    endfunction

    assign bus.igen_imm_i = imm_of(bus.igen_insn_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  opc_tab[8] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], opc_tab[$urandom_range(0, 7)]};
    endfunction

    // Check outputs mid-cycle, advance the model with this cycle's inputs, cross the edge.
    task automatic step();
        int   n;
        logic acc;
        logic [31:0] exp_ig;
        @(negedge clk);
        n = held.size();
        chk_val("f_ready", bus.f_ready_o, n < 2);
        chk_val("d_valid", bus.d_valid_o, n > 0);
        if (n > 0) begin
            chk_val("d_pc",   bus.d_pc_o,   held[0].pc);
            chk_val("d_insn", bus.d_insn_o, held[0].insn);
            chk_val("d_imm",  bus.d_imm_o,  held[0].imm);
        end
        exp_ig = (n == 2) ? held[1].insn : bus.f_insn_i;
        chk_val("igen_insn",   bus.igen_insn_o,   exp_ig);
        chk_val("igen_opcode", bus.igen_opcode_o, exp_ig[6:0]);
        chk_val("stall_cnt",   bus.stall_cnt_o,   stall_m);
        if (n > 0 && !bus.d_ready_i && stall_m < STALL_MAX) stall_m++;
        if (bus.flush_i) begin
            held.delete();
        end else begin
            acc = bus.f_valid_i && (n < 2);
            if (n > 0 && bus.d_ready_i) void'(held.pop_front());
            if (acc) held.push_back('{bus.f_pc_i, bus.f_insn_i, imm_of(bus.f_insn_i)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_valid_i = 1'b0;
        bus.f_pc_i    = '0;
        bus.f_insn_i  = '0;
        bus.flush_i   = 1'b0;
        bus.d_ready_i = 1'b0;
    endtask

    // Asynchronous reset at the current (mid-cycle) time, released on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_val("rst_d_valid", bus.d_valid_o,   0);
        chk_val("rst_f_ready", bus.f_ready_o,   1);
        chk_val("rst_d_insn",  bus.d_insn_o,    32'h0000_0013);
        chk_val("rst_d_pc",    bus.d_pc_o,      0);
        chk_val("rst_d_imm",   bus.d_imm_o,     0);
        chk_val("rst_stall",   bus.stall_cnt_o, 0);
        held.delete();
        stall_m = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] insn);
        bus.f_valid_i = 1'b1;
        bus.f_pc_i    = pc;
        bus.f_insn_i  = insn;
    endtask

    initial begin
        logic [31:0] stream[3] = '{32'h1234_52B7, 32'h0040_006F, 32'h0050_9093};
        logic [31:0] s_imm[3]  = '{32'h1234_5000, 32'h0000_0004, 32'h0000_0005};
        n_chk   = 0;
        n_pass  = 0;
        stall_m = 0;
        idle_inputs();
        #2;
        do_reset();

        // single addi
        offer(32'h0100_0000, 32'hFFF0_0093);
        bus.d_ready_i = 1'b1;
        step();
        bus.f_valid_i = 1'b0;
        chk_val("addi_valid", bus.d_valid_o, 1);
        chk_val("addi_imm",   bus.d_imm_o,   32'hFFFF_FFFF);
        chk_val("addi_pc",    bus.d_pc_o,    32'h0100_0000);
        step();

        // back-to-back stream
        for (int i = 0; i < 3; i++) begin
            offer(32'h0000_1000 + 4 * i, stream[i]);
            step();
            chk_val("stream_imm", bus.d_imm_o, s_imm[i]);
        end
        bus.f_valid_i = 1'b0;
        step();
        step();

        // backpressure into skid
        do_reset();
        bus.d_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h0000_2000 + 4 * i, rand_insn());
            step();
        end
        chk_val("bp_f_ready", bus.f_ready_o,   0);
        chk_val("bp_stall",   bus.stall_cnt_o, 2);
        bus.d_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.f_valid_i = 1'b0;
        step();
        step();

        // flush in FULL with a fetch offered
        do_reset();
        bus.d_ready_i = 1'b0;
        offer(32'h0000_3000, rand_insn());
        step();
        offer(32'h0000_3004, rand_insn());
        step();
        offer(32'h0000_3008, rand_insn());
        bus.flush_i = 1'b1;
        step();
        bus.flush_i   = 1'b0;
        bus.f_valid_i = 1'b0;
        chk_val("flush_d_valid", bus.d_valid_o, 0);
        chk_val("flush_f_ready", bus.f_ready_o, 1);
        bus.d_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // async reset while FULL
        bus.d_ready_i = 1'b0;
        offer(32'h0000_4000, rand_insn());
        step();
        offer(32'h0000_4004, rand_insn());
        step();
        bus.f_valid_i = 1'b0;
        step();
        #2;
        do_reset();

        // stall counter saturation
        offer(32'h0000_5000, rand_insn());
        step();
        bus.f_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk_val("stall_sat", bus.stall_cnt_o, STALL_MAX);
        bus.d_ready_i = 1'b1;
        step();

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.f_valid_i = ($urandom_range(0, 9) < 7);
            bus.f_pc_i    = $urandom();
            bus.f_insn_i  = rand_insn();
            bus.d_ready_i = ($urandom_range(0, 9) < 6);
            bus.flush_i   = ($urandom_range(0, 19) == 0);
            step();
            if (c == 300) begin
                #2;
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
